// File: rtl/cpu_sdr_cache.sv
// cpu_sdr_cache
// Direct-mapped, write-through read cache between the 68000 SDRAM request
// port and the SDRAM controller CPU channel. Both sides use toggle req/ack.
// Read misses fill a whole line with sequential single-word reads; writes
// always go downstream and patch the cached word on a hit (no allocate).
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   cpu_addr/data/be/rw   CPU request payload (word address), held while pending
//   cpu_req / cpu_ack     CPU toggle handshake, pending while they differ
//   cpu_q                 read data, valid when cpu_ack toggles
//   sdr_addr/data/be/rw   downstream request payload
//   sdr_req / sdr_ack     downstream toggle handshake
//   sdr_q                 downstream read data, valid when sdr_ack == sdr_req
module cpu_sdr_cache #(
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned LINE_LOG2  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] cpu_addr,
  input  logic [15:0] cpu_data,
  input  logic [1:0]  cpu_be,
  input  logic        cpu_rw,
  input  logic        cpu_req,
  output logic        cpu_ack,
  output logic [15:0] cpu_q,
  output logic [25:0] sdr_addr,
  output logic [15:0] sdr_data,
  output logic [1:0]  sdr_be,
  output logic        sdr_rw,
  output logic        sdr_req,
  input  logic        sdr_ack,
  input  logic [15:0] sdr_q
);

  localparam int unsigned ADDR_W  = 26;
  localparam int unsigned TAG_W   = ADDR_W - INDEX_BITS - LINE_LOG2;
  localparam int unsigned DADDR_W = INDEX_BITS + LINE_LOG2;
  localparam int unsigned BASE_W  = ADDR_W - LINE_LOG2;
  localparam int unsigned LINES   = 1 << INDEX_BITS;
  localparam int unsigned DWORDS  = 1 << DADDR_W;
  localparam int unsigned WORDS   = 1 << LINE_LOG2;

  localparam logic [2:0] ST_CLEAR   = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_LOOKUP  = 3'd2;
  localparam logic [2:0] ST_COMPARE = 3'd3;
  localparam logic [2:0] ST_FILL    = 3'd4;
  localparam logic [2:0] ST_WRITE   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [INDEX_BITS-1:0] clr_idx_q, clr_idx_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [1:0]            be_q, be_d;
  logic                  rw_q, rw_d;
  logic [LINE_LOG2-1:0]  cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic [15:0]           cpu_q_q, cpu_q_d;
  logic [ADDR_W-1:0]     sdr_addr_q, sdr_addr_d;
  logic [15:0]           sdr_data_q, sdr_data_d;
  logic [1:0]            sdr_be_q, sdr_be_d;
  logic                  sdr_rw_q, sdr_rw_d;
  logic                  sdr_req_q, sdr_req_d;

  // Storage: data RAM with byte enables, tag RAM holding {valid, tag}
  logic [15:0]           dram [DWORDS];
  logic [TAG_W:0]        tram [LINES];
  logic [15:0]           dram_rdata_q;
  logic [TAG_W:0]        tram_rdata_q;
  logic [1:0]            dram_we;
  logic [DADDR_W-1:0]    dram_waddr;
  logic [15:0]           dram_wdata;
  logic                  tram_we;
  logic [INDEX_BITS-1:0] tram_waddr;
  logic [TAG_W:0]        tram_wdata;

  // Fields of the latched request address
  logic [LINE_LOG2-1:0]  addr_off;
  logic [INDEX_BITS-1:0] addr_idx;
  logic [TAG_W-1:0]      addr_tag;
  logic [BASE_W-1:0]     addr_base;
  logic                  hit;
  logic                  sdr_idle;
  logic                  cnt_last;

  assign addr_off  = addr_q[LINE_LOG2-1:0];
  assign addr_idx  = addr_q[LINE_LOG2 +: INDEX_BITS];
  assign addr_tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign addr_base = addr_q[ADDR_W-1 -: BASE_W];
  assign hit       = tram_rdata_q[TAG_W] && (tram_rdata_q[TAG_W-1:0] == addr_tag);
  assign sdr_idle  = (sdr_req_q == sdr_ack);
  assign cnt_last  = (cnt_q == LINE_LOG2'(WORDS - 1));

  assign cpu_ack  = cpu_ack_q;
  assign cpu_q    = cpu_q_q;
  assign sdr_addr = sdr_addr_q;
  assign sdr_data = sdr_data_q;
  assign sdr_be   = sdr_be_q;
  assign sdr_rw   = sdr_rw_q;
  assign sdr_req  = sdr_req_q;

  // Data RAM: per-byte write, synchronous read of the latched address
  always_ff @(posedge clk) begin
    if (dram_we[0]) dram[dram_waddr][7:0]  <= dram_wdata[7:0];
    if (dram_we[1]) dram[dram_waddr][15:8] <= dram_wdata[15:8];
    dram_rdata_q <= dram[{addr_idx, addr_off}];
  end

  // Tag RAM: synchronous read of the latched index
  always_ff @(posedge clk) begin
    if (tram_we) tram[tram_waddr] <= tram_wdata;
    tram_rdata_q <= tram[addr_idx];
  end

  // Next-state and datapath control; nothing is issued or written in reset
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rw_d       = rw_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    cpu_ack_d  = cpu_ack_q;
    cpu_q_d    = cpu_q_q;
    sdr_addr_d = sdr_addr_q;
    sdr_data_d = sdr_data_q;
    sdr_be_d   = sdr_be_q;
    sdr_rw_d   = sdr_rw_q;
    sdr_req_d  = sdr_req_q;
    dram_we    = 2'b00;
    dram_waddr = {addr_idx, addr_off};
    dram_wdata = wdata_q;
    tram_we    = 1'b0;
    tram_waddr = clr_idx_q;
    tram_wdata = '0;

    if (!reset) begin
      case (state_q)
        ST_CLEAR: begin
          tram_we = 1'b1;
          // Hold on the last entry until any request left over from
          // before reset has been acknowledged.
          if (clr_idx_q != INDEX_BITS'(LINES - 1)) begin
            clr_idx_d = clr_idx_q + INDEX_BITS'(1);
          end else if (sdr_idle) begin
            state_d = ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (cpu_req != cpu_ack_q) begin
            addr_d  = cpu_addr;
            wdata_d = cpu_data;
            be_d    = cpu_be;
            rw_d    = cpu_rw;
            state_d = ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          state_d = ST_COMPARE;
        end

        ST_COMPARE: begin
          if (rw_q) begin
            if (hit) begin
              cpu_q_d   = dram_rdata_q;
              cpu_ack_d = ~cpu_ack_q;
              state_d   = ST_IDLE;
            end else begin
              cnt_d   = '0;
              busy_d  = 1'b0;
              state_d = ST_FILL;
            end
          end else begin
            if (hit) dram_we = be_q;
            busy_d  = 1'b0;
            state_d = ST_WRITE;
          end
        end

        ST_FILL: begin
          if (!busy_q) begin
            if (sdr_idle) begin
              sdr_req_d  = ~sdr_req_q;
              sdr_addr_d = {addr_base, cnt_q};
              sdr_be_d   = 2'b11;
              sdr_rw_d   = 1'b1;
              busy_d     = 1'b1;
            end
          end else if (sdr_idle) begin
            dram_we    = 2'b11;
            dram_waddr = {addr_idx, cnt_q};
            dram_wdata = sdr_q;
            if (cnt_q == addr_off) cpu_q_d = sdr_q;
            busy_d = 1'b0;
            cnt_d  = cnt_q + LINE_LOG2'(1);
            if (cnt_last) begin
              tram_we    = 1'b1;
              tram_waddr = addr_idx;
              tram_wdata = {1'b1, addr_tag};
              cpu_ack_d  = ~cpu_ack_q;
              state_d    = ST_IDLE;
            end
          end
        end

        ST_WRITE: begin
          if (!busy_q) begin
            if (sdr_idle) begin
              sdr_req_d  = ~sdr_req_q;
              sdr_addr_d = addr_q;
              sdr_data_d = wdata_q;
              sdr_be_d   = be_q;
              sdr_rw_d   = 1'b0;
              busy_d     = 1'b1;
            end
          end else if (sdr_idle) begin
            busy_d    = 1'b0;
            cpu_ack_d = ~cpu_ack_q;
            state_d   = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_CLEAR;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rw_q       <= 1'b1;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      cpu_ack_q  <= cpu_req;
      cpu_q_q    <= '0;
      sdr_addr_q <= '0;
      sdr_data_q <= '0;
      sdr_be_q   <= '0;
      sdr_rw_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rw_q       <= rw_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      cpu_ack_q  <= cpu_ack_d;
      cpu_q_q    <= cpu_q_d;
      sdr_addr_q <= sdr_addr_d;
      sdr_data_q <= sdr_data_d;
      sdr_be_q   <= sdr_be_d;
      sdr_rw_q   <= sdr_rw_d;
    end
  end

  // sdr_req keeps its level through reset so an outstanding request stays
  // matched against the controller's ack.
  always_ff @(posedge clk) begin
    sdr_req_q <= sdr_req_d;
  end

endmodule

// File: tb/tb_cpu_sdr_cache.sv
// Testbench for cpu_sdr_cache: SDRAM controller model with a backing store,
// and a line-level cache model (valid/tag per index) predicting hit or miss,
// returned data, downstream traffic and hit latency.
module tb_cpu_sdr_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic [25:0] cpu_addr;
  logic [15:0] cpu_data;
  logic [1:0]  cpu_be;
  logic        cpu_rw;
  logic        cpu_req;
  logic        cpu_ack;
  logic [15:0] cpu_q;
  logic [25:0] sdr_addr;
  logic [15:0] sdr_data;
  logic [1:0]  sdr_be;
  logic        sdr_rw;
  logic        sdr_req;
  logic        sdr_ack;
  logic [15:0] sdr_q;

  cpu_sdr_cache dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_be   (cpu_be),
    .cpu_rw   (cpu_rw),
    .cpu_req  (cpu_req),
    .cpu_ack  (cpu_ack),
    .cpu_q    (cpu_q),
    .sdr_addr (sdr_addr),
    .sdr_data (sdr_data),
    .sdr_be   (sdr_be),
    .sdr_rw   (sdr_rw),
    .sdr_req  (sdr_req),
    .sdr_ack  (sdr_ack),
    .sdr_q    (sdr_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [1:0]  be;
    logic [15:0] data;
    logic [25:0] addr;
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Controller model state
  logic [15:0] mem [int];
  txn_t        txn_log[$];
  txn_t        cur;
  int          n_tog = 0;
  int          n_rd  = 0;
  int          n_wr  = 0;
  bit          pend  = 1'b0;
  bit          init_done = 1'b0;
  int          left  = 0;
  int          lat_cfg = 2;
  bit          lat_rand = 1'b0;
  logic        last_req;

  // Cache model: which tag each line holds
  bit          m_valid [256];
  int          m_tag   [256];

  // Snapshot of the request in flight
  logic        s_rw;
  logic [25:0] s_a;
  logic [15:0] s_d;
  logic [1:0]  s_be;
  bit          s_hit;
  int          s_nr, s_nw, s_tog;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [25:0] a);
    logic [15:0] v;
    if (mem.exists(int'(a))) v = mem[int'(a)];
    else v = a[15:0] ^ 16'hA5C3;
    return v;
  endfunction

  // SDRAM controller: one request at a time, ack after a chosen latency
  always @(negedge clk) begin
    logic [15:0] w;
    if (!init_done) begin
      last_req  = sdr_req;
      sdr_ack   = sdr_req;
      sdr_q     = 16'h0;
      init_done = 1'b1;
    end else if (sdr_req !== last_req) begin
      last_req = sdr_req;
      n_tog++;
      check_eq("sdr_single_outstanding", 32'(pend), 32'(0));
      pend = 1'b1;
      cur  = '{rw: sdr_rw, be: sdr_be, data: sdr_data, addr: sdr_addr};
      left = lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
    end else if (pend) begin
      if (left > 1) begin
        left--;
      end else begin
        if (cur.rw) begin
          sdr_q = mem_rd(cur.addr);
          n_rd++;
        end else begin
          w = mem_rd(cur.addr);
          if (cur.be[0]) w[7:0]  = cur.data[7:0];
          if (cur.be[1]) w[15:8] = cur.data[15:8];
          mem[int'(cur.addr)] = w;
          n_wr++;
        end
        txn_log.push_back(cur);
        sdr_ack = last_req;
        pend    = 1'b0;
      end
    end
  end

  task automatic start_op(input logic rw, input logic [25:0] a, input logic [15:0] d,
                          input logic [1:0] be);
    int idx;
    idx   = (int'(a) >> 2) & 255;
    s_rw  = rw; s_a = a; s_d = d; s_be = be;
    s_hit = m_valid[idx] && (m_tag[idx] == (int'(a) >> 10));
    s_nr  = n_rd; s_nw = n_wr; s_tog = n_tog;
    txn_log.delete();
    cpu_addr = a; cpu_data = d; cpu_be = be; cpu_rw = rw;
    cpu_req  = ~cpu_req;
  endtask

  task automatic end_op();
    int cyc;
    int idx;
    int base;
    cyc  = 0;
    idx  = (int'(s_a) >> 2) & 255;
    base = int'(s_a) & ~3;
    do begin
      @(negedge clk);
      cyc++;
    end while (cpu_ack != cpu_req && cyc < 4000);
    check_eq("cpu_ack_returned", 32'(cpu_ack), 32'(cpu_req));
    if (s_rw) begin
      check_eq("read_data", 32'(cpu_q), 32'(mem_rd(s_a)));
      if (s_hit) begin
        check_eq("hit_latency", 32'(cyc), 32'(3));
        check_eq("hit_sdr_toggles", 32'(n_tog - s_tog), 32'(0));
      end else begin
        check_eq("miss_sdr_toggles", 32'(n_tog - s_tog), 32'(4));
        check_eq("miss_sdr_reads", 32'(n_rd - s_nr), 32'(4));
        for (int i = 0; i < 4 && i < txn_log.size(); i++) begin
          check_eq("fill_addr", 32'(txn_log[i].addr), 32'(base + i));
          check_eq("fill_be", 32'(txn_log[i].be), 32'(3));
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = int'(s_a) >> 10;
      end
    end else begin
      check_eq("write_sdr_toggles", 32'(n_tog - s_tog), 32'(1));
      check_eq("write_sdr_writes", 32'(n_wr - s_nw), 32'(1));
      if (txn_log.size() > 0) begin
        check_eq("write_addr", 32'(txn_log[0].addr), 32'(s_a));
        check_eq("write_data", 32'(txn_log[0].data), 32'(s_d));
        check_eq("write_be", 32'(txn_log[0].be), 32'(s_be));
      end
    end
  endtask

  task automatic do_op(input logic rw, input logic [25:0] a, input logic [15:0] d,
                       input logic [1:0] be);
    @(negedge clk);
    start_op(rw, a, d, be);
    end_op();
  endtask

  task automatic assert_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  initial begin
    int n;
    int t0, t_r;
    logic r0;
    logic [25:0] a;
    reset = 1'b1; cpu_addr = '0; cpu_data = '0; cpu_be = '0; cpu_rw = 1'b1; cpu_req = 1'b0;
    for (int i = 0; i < 256; i++) begin m_valid[i] = 1'b0; m_tag[i] = 0; end
    repeat (3) @(negedge clk);

    check_eq("rst_cpu_ack", 32'(cpu_ack), 32'(cpu_req));
    check_eq("rst_cpu_q", 32'(cpu_q), 32'(0));
    check_eq("rst_sdr_addr", 32'(sdr_addr), 32'(0));
    check_eq("rst_sdr_data", 32'(sdr_data), 32'(0));
    check_eq("rst_sdr_be", 32'(sdr_be), 32'(0));
    check_eq("rst_sdr_rw", 32'(sdr_rw), 32'(1));

    // Read issued as reset releases: 256 clear cycles, IDLE/LOOKUP/COMPARE,
    // then the first fill read goes out from FILL.
    r0 = sdr_req;
    reset = 1'b0;
    start_op(1'b1, 26'h10, 16'h0, 2'b11);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sdr_req == r0 && n < 2000);
    check_eq("clear_then_first_fill_req", 32'(n), 32'(256 + 3 + 1));
    end_op();

    // Directed: hits in the filled line, partial write on a hit, no-allocate
    // write, and eviction by an aliasing tag.
    do_op(1'b1, 26'h12, 16'h0, 2'b11);
    do_op(1'b1, 26'h13, 16'h0, 2'b11);
    do_op(1'b0, 26'h10, 16'hAAAA, 2'b11);
    do_op(1'b1, 26'h10, 16'h0, 2'b11);
    do_op(1'b0, 26'h10, 16'h1234, 2'b01);
    do_op(1'b1, 26'h10, 16'h0, 2'b11);
    check_eq("byte_merge_value", 32'(cpu_q), 32'(16'hAA34));
    do_op(1'b0, 26'h400, 16'h5555, 2'b11);
    do_op(1'b1, 26'h400, 16'h0, 2'b11);
    do_op(1'b1, 26'h1010, 16'h0, 2'b11);
    do_op(1'b1, 26'h10, 16'h0, 2'b11);

    // Random mix over a few aliasing lines with random controller latency
    lat_rand = 1'b1;
    for (int k = 0; k < 150; k++) begin
      a = 26'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      do_op(1'(($urandom_range(0, 2) != 0)), a, 16'($urandom), 2'($urandom_range(0, 3)));
    end

    // Reset in the middle of a fill with a slow controller ack
    lat_rand = 1'b0;
    lat_cfg  = 5;
    assert_reset(2);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    t0 = n_tog;
    start_op(1'b1, 26'h10, 16'h0, 2'b11);
    n = 0;
    while (n_tog < t0 + 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("fill_progress_before_reset", 32'(n_tog - t0), 32'(3));
    t_r = n_tog;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    n = 0;
    while (pend && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("late_ack_drained", 32'(pend), 32'(0));
    check_eq("no_req_before_late_ack", 32'(n_tog), 32'(t_r));
    repeat (300) @(negedge clk);
    check_eq("no_req_after_reset", 32'(n_tog), 32'(t_r));
    check_eq("pending_req_dropped", 32'(cpu_ack), 32'(cpu_req));
    do_op(1'b1, 26'h10, 16'h0, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks made", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
